// File: rtl/ag_pkg.sv
// Shared types for the multi-channel buffer address generator.
package ag_pkg;

  localparam logic MODE_ROW = 1'b0;
  localparam logic MODE_COL = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ag_state_t;

  typedef enum logic {
    ROW_MAJOR = MODE_ROW,
    COL_MAJOR = MODE_COL
  } ag_mode_t;

endpackage

// File: rtl/ag_cnt.sv
// Wrap counter with enable, run-time maximum, synchronous clear and carry-out.
// nxt_o is the value the counter takes at the coming edge.
module ag_cnt #(
  parameter int unsigned W = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] max_i,
  output logic [W-1:0] nxt_o,
  output logic         carry_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise wrap to zero after max_i.
  always_comb begin
    cnt_d   = cnt_q;
    carry_o = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (cnt_q == max_i) begin
        cnt_d   = '0;
        carry_o = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign nxt_o = cnt_d;

  // Count register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ag_buf.sv
// Multi-channel row/column-major address generator for the systolic array buffers.
module ag_buf
  import ag_pkg::*;
#(
  parameter  int unsigned FEATURE_BITS = 4,
  parameter  int unsigned ADDR_W       = 2 * FEATURE_BITS,
  parameter  int unsigned CHANNELS     = 2,
  localparam int unsigned CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                    sys_clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [FEATURE_BITS-1:0] m_cfg,
  input  logic [FEATURE_BITS-1:0] n_cfg,
  input  logic                    mode,
  input  logic [ADDR_W-1:0]       base,
  input  logic                    stall,
  output logic                    busy,
  output logic                    valid,
  output logic [ADDR_W-1:0]       address,
  output logic [CH_W-1:0]         channel,
  output logic                    last,
  output logic                    done
);

  ag_state_t               state_q;
  ag_mode_t                mode_q;
  logic [FEATURE_BITS-1:0] m_q, n_q;
  logic [ADDR_W-1:0]       base_q, mn_q, row_off_q, ch_off_q;
  logic [ADDR_W-1:0]       row_off_d, ch_off_d, addr_d;
  logic [ADDR_W-1:0]       addr_q;
  logic [CH_W-1:0]         chan_q;
  logic                    busy_q, valid_q, last_q, done_q, last_d;

  logic                    accept, nonempty, adv;
  logic [FEATURE_BITS-1:0] inner_max, outer_max, inner_nxt, outer_nxt, c_nxt;
  logic [CH_W-1:0]         ch_nxt;
  logic                    inner_carry, outer_carry, ch_carry;
  logic                    outer_en, ch_en, r_en, r_carry;

  assign accept    = (state_q == IDLE) && start;
  assign nonempty  = (m_cfg != '0) && (n_cfg != '0);
  assign adv       = (state_q == RUN) && !stall;
  assign inner_max = (mode_q == COL_MAJOR) ? m_q - 1'b1 : n_q - 1'b1;
  assign outer_max = (mode_q == COL_MAJOR) ? n_q - 1'b1 : m_q - 1'b1;
  assign outer_en  = adv && inner_carry;
  assign ch_en     = outer_en && outer_carry;

  ag_cnt #(.W(FEATURE_BITS)) u_inner (
    .clk_i(sys_clk), .rst_ni(reset_n), .clr_i(accept), .en_i(adv),
    .max_i(inner_max), .nxt_o(inner_nxt), .carry_o(inner_carry)
  );

  ag_cnt #(.W(FEATURE_BITS)) u_outer (
    .clk_i(sys_clk), .rst_ni(reset_n), .clr_i(accept), .en_i(outer_en),
    .max_i(outer_max), .nxt_o(outer_nxt), .carry_o(outer_carry)
  );

  ag_cnt #(.W(CH_W)) u_chan (
    .clk_i(sys_clk), .rst_ni(reset_n), .clr_i(accept), .en_i(ch_en),
    .max_i(CH_W'(CHANNELS - 1)), .nxt_o(ch_nxt), .carry_o(ch_carry)
  );

  // Map inner/outer back to row/column according to the latched sweep mode.
  assign r_en    = (mode_q == COL_MAJOR) ? adv         : outer_en;
  assign r_carry = (mode_q == COL_MAJOR) ? inner_carry : outer_carry;
  assign c_nxt   = (mode_q == COL_MAJOR) ? outer_nxt   : inner_nxt;

  // Running offsets r*n and ch*m*n; the address is a pure sum of them.
  always_comb begin
    row_off_d = row_off_q;
    ch_off_d  = ch_off_q;
    if (accept) begin
      row_off_d = '0;
      ch_off_d  = '0;
    end else begin
      if (r_en)  row_off_d = r_carry  ? '0 : row_off_q + ADDR_W'(n_q);
      if (ch_en) ch_off_d  = ch_carry ? '0 : ch_off_q + mn_q;
    end
    addr_d = base_q + ch_off_d + row_off_d + ADDR_W'(c_nxt);
    last_d = (ch_nxt == CH_W'(CHANNELS - 1)) && (inner_nxt == inner_max) &&
             (outer_nxt == outer_max);
  end

  // Offset registers.
  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      row_off_q <= '0;
      ch_off_q  <= '0;
    end else begin
      row_off_q <= row_off_d;
      ch_off_q  <= ch_off_d;
    end
  end

  // Job FSM with registered outputs and latched configuration.
  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      mode_q  <= ROW_MAJOR;
      m_q     <= '0;
      n_q     <= '0;
      base_q  <= '0;
      mn_q    <= '0;
      addr_q  <= '0;
      chan_q  <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            m_q    <= m_cfg;
            n_q    <= n_cfg;
            mode_q <= ag_mode_t'(mode);
            base_q <= base;
            mn_q   <= ADDR_W'(m_cfg) * ADDR_W'(n_cfg);
            busy_q <= 1'b1;
            chan_q <= '0;
            if (nonempty) begin
              state_q <= RUN;
              valid_q <= 1'b1;
              addr_q  <= base;
              last_q  <= (CHANNELS == 1) && (m_cfg == FEATURE_BITS'(1)) &&
                         (n_cfg == FEATURE_BITS'(1));
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (!stall) begin
            if (last_q) begin
              state_q <= DONE;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              addr_q <= addr_d;
              chan_q <= ch_nxt;
              last_q <= last_d;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign valid   = valid_q;
  assign address = addr_q;
  assign channel = chan_q;
  assign last    = last_q;
  assign done    = done_q;

endmodule

// File: tb/tb_ag_buf.sv
// Scoreboard bench for ag_buf: stimulus pushes expected addresses, monitors pop and compare.
module tb_ag_buf;

  logic       clk = 1'b0;
  logic       reset_n, start0, start1, stall, mode;
  logic [3:0] m_cfg, n_cfg;
  logic [7:0] base;

  logic       busy0, valid0, last0, done0;
  logic [7:0] addr0;
  logic [0:0] ch0;
  logic       busy1, valid1, last1, done1;
  logic [7:0] addr1;
  logic [0:0] ch1;

  typedef struct packed {
    logic [7:0] a;
    logic       c;
    logic       l;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  ag_buf #(.FEATURE_BITS(4), .CHANNELS(2)) dut0 (
    .sys_clk(clk), .reset_n(reset_n), .start(start0), .m_cfg(m_cfg), .n_cfg(n_cfg),
    .mode(mode), .base(base), .stall(stall), .busy(busy0), .valid(valid0),
    .address(addr0), .channel(ch0), .last(last0), .done(done0)
  );

  ag_buf #(.FEATURE_BITS(4), .CHANNELS(1)) dut1 (
    .sys_clk(clk), .reset_n(reset_n), .start(start1), .m_cfg(m_cfg), .n_cfg(n_cfg),
    .mode(mode), .base(base), .stall(stall), .busy(busy1), .valid(valid1),
    .address(addr1), .channel(ch1), .last(last1), .done(done1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor for the two-channel instance; a stalled cycle repeats the previous entry.
  exp_t cur0;
  bit   hold0 = 1'b0;
  always @(negedge clk) begin
    if (valid0 === 1'b1) begin
      chk("valid0_with_done0", done0, 1'b0);
      if (!hold0) begin
        if (q0.size() == 0) begin
          chk("unexpected_valid0", 1, 0);
          cur0 = {addr0, ch0, last0};
        end else begin
          cur0 = q0.pop_front();
        end
      end
      chk("addr0", addr0, cur0.a);
      chk("chan0", ch0, cur0.c);
      chk("last0", last0, cur0.l);
      hold0 = stall;
    end else begin
      hold0 = 1'b0;
    end
  end

  // Monitor for the single-channel instance.
  exp_t cur1;
  bit   hold1 = 1'b0;
  always @(negedge clk) begin
    if (valid1 === 1'b1) begin
      chk("valid1_with_done1", done1, 1'b0);
      if (!hold1) begin
        if (q1.size() == 0) begin
          chk("unexpected_valid1", 1, 0);
          cur1 = {addr1, ch1, last1};
        end else begin
          cur1 = q1.pop_front();
        end
      end
      chk("addr1", addr1, cur1.a);
      chk("chan1", ch1, cur1.c);
      chk("last1", last1, cur1.l);
      hold1 = stall;
    end else begin
      hold1 = 1'b0;
    end
  end

  task automatic run_job(input int d, input int m, input int n, input int md, input int b,
                         input int stall_at, input int stall_len, input int pulse_at,
                         input int rst_at);
    int   nch, nn, idx, cyc, exp_done, il, ol, r, c;
    bit   got;
    exp_t e;
    nch = d ? 1 : 2;
    nn  = nch * m * n;
    il  = md ? m : n;
    ol  = md ? n : m;
    idx = 0;
    for (int ch = 0; ch < nch; ch++)
      for (int o = 0; o < ol; o++)
        for (int i = 0; i < il; i++) begin
          r   = md ? i : o;
          c   = md ? o : i;
          e.a = 8'((b + ch * m * n + r * n + c) & 255);
          e.c = 1'(ch);
          e.l = (idx == nn - 1);
          if (d) q1.push_back(e); else q0.push_back(e);
          idx++;
        end
    exp_done = (nn == 0) ? 1 : nn + 1 + stall_len;

    @(posedge clk); #1;
    m_cfg = 4'(m); n_cfg = 4'(n); mode = 1'(md); base = 8'(b);
    if (d) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0; start1 = 1'b0;
    cyc = 1;
    chk("busy_rise", d ? busy1 : busy0, 1'b1);
    got = 1'b0;
    while (!got && cyc <= exp_done + 4) begin
      if ((d ? done1 : done0) === 1'b1) begin
        got = 1'b1;
        chk("done_cycle", cyc, exp_done);
        chk("valid_in_done", d ? valid1 : valid0, 1'b0);
      end else begin
        if (cyc == rst_at) begin
          reset_n = 1'b0;
          @(posedge clk); #1;
          reset_n = 1'b1;
          chk("rst_busy",  busy0,  1'b0);
          chk("rst_valid", valid0, 1'b0);
          chk("rst_addr",  addr0,  8'h00);
          chk("rst_chan",  ch0,    1'b0);
          chk("rst_last",  last0,  1'b0);
          chk("rst_done",  done0,  1'b0);
          q0.delete();
          return;
        end
        if (stall_len > 0 && cyc == stall_at) stall = 1'b1;
        if (stall_len > 0 && cyc == stall_at + stall_len) stall = 1'b0;
        if (pulse_at > 0 && cyc == pulse_at) begin
          start0 = 1'b1; m_cfg = 4'd1; n_cfg = 4'd1; base = 8'hAA; mode = ~mode;
        end
        if (pulse_at > 0 && cyc == pulse_at + 1) start0 = 1'b0;
        @(posedge clk); #1;
        cyc++;
      end
    end
    if (!got) chk("done_timeout", 0, 1);
    @(posedge clk); #1;
    chk("idle_busy", d ? busy1 : busy0, 1'b0);
    chk("idle_done", d ? done1 : done0, 1'b0);
    chk("queue_drained", d ? q1.size() : q0.size(), 0);
  endtask

  initial begin
    reset_n = 1'b0; start0 = 1'b0; start1 = 1'b0; stall = 1'b0; mode = 1'b0;
    m_cfg = '0; n_cfg = '0; base = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy0",  busy0,  1'b0);
    chk("reset_valid0", valid0, 1'b0);
    chk("reset_addr0",  addr0,  8'h00);
    chk("reset_chan0",  ch0,    1'b0);
    chk("reset_last0",  last0,  1'b0);
    chk("reset_done0",  done0,  1'b0);
    chk("reset_valid1", valid1, 1'b0);
    chk("reset_busy1",  busy1,  1'b0);
    reset_n = 1'b1;

    // Row-major 9x3, two channels: 0..53, done at k+55.
    run_job(0, 9, 3, 0, 8'h00, 0, 0, 0, 0);
    // Column-major 2x3 at 0x10 with an ignored start mid-run.
    run_job(0, 2, 3, 1, 8'h10, 0, 0, 5, 0);
    // Same job, three stall cycles while 0x14 is presented.
    run_job(0, 2, 3, 1, 8'h10, 4, 3, 0, 0);
    // Empty job: done at k+1, no valid.
    run_job(0, 0, 5, 0, 8'h00, 0, 0, 0, 0);
    // Reset while address 20 is presented, then a fresh full job.
    run_job(0, 9, 3, 0, 8'h00, 0, 0, 0, 21);
    run_job(0, 9, 3, 0, 8'h00, 0, 0, 0, 0);
    // Modulo-256 wrap on the single-channel instance, last at 0xD0.
    run_job(1, 15, 15, 0, 8'hF0, 0, 0, 0, 0);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
